// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Receives a byte stream and writes it into the core's instruction memory.
// The core is held in reset until the load is complete.
//
// Stream format:
//   LEN[7:0], LEN[15:8]                header: the number of 32-bit words
//   LEN*4 data bytes                   each word is sent little-endian
//   [checksum byte]                    only sent when BOOT_LOADER_CHECKSUM_EN
//                                      is defined
//
// When BOOT_LOADER_CHECKSUM_EN is defined, the block adds up the data bytes
// mod 256. The final byte must equal that sum. A matching byte starts the
// core; any other value is a load error.
//
// Ports:
//   CLK           clock; all state changes on its rising edge
//   RESET         asynchronous, active-high reset
//   RX_DATA       incoming stream byte
//   RX_VALID      RX_DATA is valid
//   RX_READY      a byte is accepted this cycle if RX_VALID is also high
//   IMEM_WADDR    instruction-memory word index
//   IMEM_WDATA    assembled instruction word
//   IMEM_WE       one-cycle write strobe
//   CORE_RESET_N  active-low core reset; goes high once the load completes
//   DONE          sticky: load completed
//   ERROR         sticky: load rejected (bad length or bad checksum)
// -----------------------------------------------------------------------------
module boot_loader #(
   parameter int SIZE       = 32,   // instruction width; only 32 is supported
   parameter int ADDR_WIDTH = 10    // instruction-memory word-address width
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [7:0]            RX_DATA,
   input  logic                  RX_VALID,
   output logic                  RX_READY,
   output logic [ADDR_WIDTH-1:0] IMEM_WADDR,
   output logic [SIZE-1:0]       IMEM_WDATA,
   output logic                  IMEM_WE,
   output logic                  CORE_RESET_N,
   output logic                  DONE,
   output logic                  ERROR
);

   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [16:0]         LEN_MAX = 17'(1) << ADDR_WIDTH;

   typedef enum logic [2:0] {
      HDR0,
      HDR1,
      DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
      CKSUM,
`endif
      RUN,
      ERR
   } state_t;

   state_t                state;
   state_t                state_next;
   logic                  armed;        // low until the first edge after reset
   logic                  accept;
   logic [7:0]            len_lo;
   logic [ADDR_WIDTH:0]   len_q;
   logic [16:0]           len_full;
   logic                  len_bad;
   logic [1:0]            byte_cnt;
   // One bit wider than the address, so LEN = 2^ADDR_WIDTH can be counted
   // without wrapping.
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [SIZE-9:0]       word_buf;     // holds the first three bytes of a word
   logic                  last_word;
   logic                  run_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [7:0]            sum;
`endif

   assign accept    = RX_VALID & RX_READY;
   assign len_full  = {1'b0, RX_DATA, len_lo};
   assign len_bad   = (len_full == 17'd0) || (len_full > LEN_MAX);
   assign last_word = (word_cnt + CNT_ONE) == len_q;

   // ---------------------------------------------------------------- state
   // NOTE: sequential state is updated with non-blocking assignments, so
   // every flop samples values from before the clock edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= HDR0;
      else       state <= state_next;
   end

   // ----------------------------------------------------------- next state
   // NOTE: state_next gets a default before the case statement. This means
   // no path through the block leaves it unassigned, so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         HDR0: if (accept) state_next = HDR1;
         HDR1: if (accept) state_next = len_bad ? ERR : DATA;
         DATA: begin
            if (accept && byte_cnt == 2'd3 && last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
               state_next = CKSUM;
`else
               state_next = RUN;
`endif
            end
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         CKSUM: if (accept) state_next = (RX_DATA == sum) ? RUN : ERR;
`endif
         RUN:     state_next = RUN;
         ERR:     state_next = ERR;
         default: state_next = ERR;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      RX_READY = 1'b0;
      ERROR    = 1'b0;
      case (state)
         HDR0, HDR1, DATA: RX_READY = armed;
`ifdef BOOT_LOADER_CHECKSUM_EN
         CKSUM:            RX_READY = armed;
`endif
         ERR:              ERROR    = 1'b1;
         default:          RX_READY = 1'b0;
      endcase
   end

   // Start-up is delayed by one flop stage after entering RUN. As a result,
   // DONE and CORE_RESET_N go high the cycle after the final write strobe,
   // never in the same cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         armed <= 1'b0;
         run_q <= 1'b0;
      end else begin
         armed <= 1'b1;
         run_q <= (state == RUN);
      end
   end

   assign CORE_RESET_N = run_q;
   assign DONE         = run_q;

   // ------------------------------------------------------------- datapath
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         len_lo     <= '0;
         len_q      <= '0;
         byte_cnt   <= '0;
         word_cnt   <= '0;
         word_buf   <= '0;
         IMEM_WE    <= 1'b0;
         IMEM_WADDR <= '0;
         IMEM_WDATA <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         IMEM_WE <= 1'b0;
         if (accept) begin
            case (state)
               HDR0: len_lo <= RX_DATA;
               HDR1: len_q  <= len_full[ADDR_WIDTH:0];
               DATA: begin
                  byte_cnt <= byte_cnt + 2'd1;   // wraps 3 -> 0
`ifdef BOOT_LOADER_CHECKSUM_EN
                  sum      <= sum + RX_DATA;
`endif
                  case (byte_cnt)
                     2'd0: word_buf[7:0]   <= RX_DATA;
                     2'd1: word_buf[15:8]  <= RX_DATA;
                     2'd2: word_buf[23:16] <= RX_DATA;
                     default: begin
                        IMEM_WE    <= 1'b1;
                        IMEM_WADDR <= word_cnt[ADDR_WIDTH-1:0];
                        IMEM_WDATA <= {RX_DATA, word_buf};
                        word_cnt   <= word_cnt + CNT_ONE;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Directed testbench for boot_loader. Each test drives a hand-built byte
// stream. A negedge monitor logs every IMEM_WE strobe along with its cycle
// number. All expected values are hand-computed constants or are derived from
// the stream the bench itself built. Checksum tests are compiled in only when
// BOOT_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_boot_loader;

   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic [7:0]    RX_DATA = 8'h00;
   logic          RX_VALID = 1'b0;
   logic          RX_READY;
   logic [AW-1:0] IMEM_WADDR;
   logic [31:0]   IMEM_WDATA;
   logic          IMEM_WE;
   logic          CORE_RESET_N;
   logic          DONE;
   logic          ERROR;

   boot_loader #(.SIZE(32), .ADDR_WIDTH(AW)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .RX_DATA      (RX_DATA),
      .RX_VALID     (RX_VALID),
      .RX_READY     (RX_READY),
      .IMEM_WADDR   (IMEM_WADDR),
      .IMEM_WDATA   (IMEM_WDATA),
      .IMEM_WE      (IMEM_WE),
      .CORE_RESET_N (CORE_RESET_N),
      .DONE         (DONE),
      .ERROR        (ERROR)
   );

   always #5 CLK = ~CLK;

   // ------------------------------------------------------------ checking
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------- monitor
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   int            cyc = 0;
   int            last_we_cyc = -1;
   int            done_rise_cyc = -1;
   int            overlap = 0;
   logic          prev_done = 1'b0;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (IMEM_WE === 1'b1) begin
         wr_addr.push_back(IMEM_WADDR);
         wr_data.push_back(IMEM_WDATA);
         last_we_cyc = cyc;
         if (DONE === 1'b1 || CORE_RESET_N === 1'b1) overlap++;
      end
      if (DONE === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
      prev_done = DONE;
   end

   // ------------------------------------------------------------ stimulus
   logic [7:0]  stream[$];
   logic [31:0] exp_words[$];

   // Called at posedge+1. Waits `gap` idle cycles, then holds RX_VALID until
   // the byte is accepted, giving up after a bounded number of cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      int budget = 0;
      repeat (gap) begin
         RX_VALID = 1'b0;
         RX_DATA  = 8'hEE;
         @(posedge CLK); #1;
      end
      RX_VALID = 1'b1;
      RX_DATA  = b;
      while (!ok && budget < 50) begin
         @(negedge CLK);
         ok = (RX_READY === 1'b1);
         @(posedge CLK); #1;
         budget++;
      end
      RX_VALID = 1'b0;
      RX_DATA  = 8'hEE;
      if (!ok) check("rx_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_stream(input int gap);
      foreach (stream[i]) send_byte(stream[i], gap);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RX_VALID = 1'b0;
      RESET    = 1'b1;
      @(posedge CLK); #1;
      RESET    = 1'b0;
   endtask

   // Appends the checksum byte (sum of all bytes after the 2-byte header)
   // when the checksum feature is compiled in.
   task automatic add_cksum();
`ifdef BOOT_LOADER_CHECKSUM_EN
      logic [7:0] s = 8'h00;
      for (int i = 2; i < stream.size(); i++) s = s + stream[i];
      stream.push_back(s);
`endif
   endtask

   task automatic build_load(input int len);
      logic [7:0] b;
      logic [31:0] w;
      logic [15:0] l16;
      l16 = 16'(len);
      stream.delete();
      exp_words.delete();
      stream.push_back(l16[7:0]);
      stream.push_back(l16[15:8]);
      for (int i = 0; i < len; i++) begin
         w = 32'h0;
         for (int k = 0; k < 4; k++) begin
            b = 8'(i * 7 + k * 61 + (i >> 8) * 13 + 1);
            stream.push_back(b);
            w[k*8 +: 8] = b;
         end
         exp_words.push_back(w);
      end
      add_cksum();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   int base;
   int bad;

   initial begin
      // ---------------- reset state
      #2;
      check("rst_rx_ready",     RX_READY,     0);
      check("rst_imem_we",      IMEM_WE,      0);
      check("rst_imem_waddr",   IMEM_WADDR,   0);
      check("rst_imem_wdata",   IMEM_WDATA,   0);
      check("rst_core_reset_n", CORE_RESET_N, 0);
      check("rst_done",         DONE,         0);
      check("rst_error",        ERROR,        0);
      @(posedge CLK); #1;
      check("rst_rx_ready_held", RX_READY, 0);
      RESET = 1'b0;
      @(negedge CLK);
      check("rx_ready_before_edge", RX_READY, 0);
      @(posedge CLK); #1;
      check("rx_ready_first_edge", RX_READY, 1);

      // ---------------- single word
      base = wr_addr.size();
      stream = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
      add_cksum();
      send_stream(0);
      idle(3);
      check("t1_writes", wr_addr.size() - base, 1);
      if (wr_addr.size() > base) begin
         check("t1_waddr", wr_addr[base], 0);
         check("t1_wdata", wr_data[base], 32'h00A00513);
      end
      check("t1_done",         DONE,         1);
      check("t1_core_reset_n", CORE_RESET_N, 1);
      check("t1_rx_ready",     RX_READY,     0);
      check("t1_error",        ERROR,        0);
      check("t1_overlap",      overlap,      0);
`ifndef BOOT_LOADER_CHECKSUM_EN
      check("t1_done_latency", done_rise_cyc - last_we_cyc, 1);
`else
      check("t1_done_after_we", done_rise_cyc > last_we_cyc, 1);
`endif
      // RUN is terminal: a valid byte stream is ignored.
      RX_VALID = 1'b1; RX_DATA = 8'h55;
      idle(3);
      RX_VALID = 1'b0;
      check("t1_run_no_write", wr_addr.size() - base, 1);
      check("t1_run_sticky",   DONE,                  1);

      // ---------------- three words, stalled stream
      apply_reset();
      check("t2_error_cleared", ERROR, 0);
      base = wr_addr.size();
      stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                 8'h77, 8'h88, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      add_cksum();
      send_stream(1);
      idle(3);
      check("t2_writes", wr_addr.size() - base, 3);
      if (wr_addr.size() >= base + 3) begin
         check("t2_waddr0", wr_addr[base],     0);
         check("t2_wdata0", wr_data[base],     32'h44332211);
         check("t2_waddr1", wr_addr[base + 1], 1);
         check("t2_wdata1", wr_data[base + 1], 32'h88776655);
         check("t2_waddr2", wr_addr[base + 2], 2);
         check("t2_wdata2", wr_data[base + 2], 32'hEFBEADDE);
      end
      check("t2_done", DONE, 1);

      // ---------------- bad lengths
      apply_reset();
      base = wr_addr.size();
      stream = '{8'h00, 8'h00};
      send_stream(0);
      idle(2);
      check("t3_len0_error",        ERROR,        1);
      check("t3_len0_core_reset_n", CORE_RESET_N, 0);
      check("t3_len0_rx_ready",     RX_READY,     0);
      check("t3_len0_done",         DONE,         0);
      apply_reset();
      stream = '{8'h01, 8'h04};
      send_stream(0);
      idle(2);
      check("t3_len1025_error",        ERROR,        1);
      check("t3_len1025_core_reset_n", CORE_RESET_N, 0);
      check("t3_len1025_rx_ready",     RX_READY,     0);
      check("t3_bad_len_writes",       wr_addr.size() - base, 0);

      // ---------------- reset mid-load
      apply_reset();
      base = wr_addr.size();
      stream = '{8'h03, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      send_stream(0);
      idle(2);
      check("t4_pre_writes", wr_addr.size() - base, 1);
      if (wr_addr.size() > base) check("t4_wdata0", wr_data[base], 32'hA4A3A2A1);
      RESET = 1'b1;
      #1;
      check("t4_rst_imem_we",      IMEM_WE,      0);
      check("t4_rst_imem_waddr",   IMEM_WADDR,   0);
      check("t4_rst_imem_wdata",   IMEM_WDATA,   0);
      check("t4_rst_rx_ready",     RX_READY,     0);
      check("t4_rst_done",         DONE,         0);
      check("t4_rst_core_reset_n", CORE_RESET_N, 0);
      check("t4_rst_error",        ERROR,        0);
      idle(2);
      check("t4_no_more_writes", wr_addr.size() - base, 1);
      RESET = 1'b0;
      stream = '{8'h01, 8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
      add_cksum();
      send_stream(0);
      idle(3);
      check("t4_reload_writes", wr_addr.size() - base, 2);
      if (wr_addr.size() >= base + 2) begin
         check("t4_reload_waddr", wr_addr[base + 1], 0);
         check("t4_reload_wdata", wr_data[base + 1], 32'hC4C3C2C1);
      end
      check("t4_reload_done", DONE, 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
      // ---------------- checksum good / bad
      apply_reset();
      base = wr_addr.size();
      stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      send_stream(0);
      idle(3);
      check("t5_good_done",  DONE,  1);
      check("t5_good_error", ERROR, 0);
      if (wr_addr.size() > base) check("t5_good_wdata", wr_data[base], 32'h04030201);
      apply_reset();
      base = wr_addr.size();
      stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
      send_stream(0);
      idle(3);
      check("t5_bad_error",        ERROR,        1);
      check("t5_bad_done",         DONE,         0);
      check("t5_bad_core_reset_n", CORE_RESET_N, 0);
      check("t5_bad_writes",       wr_addr.size() - base, 1);
      if (wr_addr.size() > base) check("t5_bad_wdata", wr_data[base], 32'h04030201);
`endif

      // ---------------- maximum length
      apply_reset();
      base = wr_addr.size();
      build_load(1024);
      send_stream(0);
      idle(3);
      check("t6_writes", wr_addr.size() - base, 1024);
      bad = 0;
      if (wr_addr.size() >= base + 1024) begin
         for (int i = 0; i < 1024; i++) begin
            if (wr_addr[base + i] !== AW'(i) || wr_data[base + i] !== exp_words[i]) bad++;
         end
         check("t6_last_waddr", wr_addr[base + 1023], 1023);
      end
      check("t6_word_mismatches", bad,   0);
      check("t6_done",            DONE,  1);
      check("t6_error",           ERROR, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
